// File: rtl/bids22_log_pkg.sv
// Shared types for the bids22 result logger: winner codes, edge FSM states, record layout.
// Optional macro BIDS22_LOG_TIMESTAMP_EN adds a 16-bit capture-cycle timestamp to each record.
package bids22_log_pkg;

  localparam int unsigned LOG_ROUND_W = 8;
  localparam int unsigned AMT_W       = 32;
  localparam int unsigned TS_W        = 16;

  typedef enum logic [2:0] {
    WIN_NONE  = 3'd0,
    WIN_X     = 3'd1,
    WIN_Y     = 3'd2,
    WIN_Z     = 3'd3,
    WIN_MULTI = 3'd4
  } winner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } edge_state_e;

  typedef struct packed {
    logic [LOG_ROUND_W-1:0] round_id;
    winner_e                winner;
    logic [AMT_W-1:0]       amount;
`ifdef BIDS22_LOG_TIMESTAMP_EN
    logic [TS_W-1:0]        ts;
`endif
  } log_rec_t;

  localparam int unsigned REC_W = $bits(log_rec_t);

  // One-hot check of the three win flags.
  function automatic winner_e decode_win(input logic x, input logic y, input logic z);
    case ({x, y, z})
      3'b000:  return WIN_NONE;
      3'b100:  return WIN_X;
      3'b010:  return WIN_Y;
      3'b001:  return WIN_Z;
      default: return WIN_MULTI;
    endcase
  endfunction

endpackage

// File: rtl/bids22_log_fifo.sv
// Generic synchronous first-word-fall-through FIFO; push and pop together are accepted when full.
module bids22_log_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == CW'(DEPTH));
  assign o_empty   = (o_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !i_clear && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/bids22_result_log.sv
// Turns each bids22 auction round into a result record, buffers it, and keeps win/drop statistics.
// Optional macro BIDS22_LOG_TIMESTAMP_EN stamps records with a free-running cycle counter.
module bids22_result_log
  import bids22_log_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ROUND_W = LOG_ROUND_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    roundOver,
  input  logic                    X_win,
  input  logic                    Y_win,
  input  logic                    Z_win,
  input  logic [31:0]             maxBid,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [REC_W-1:0]        rec_data,
  output logic [$clog2(DEPTH):0]  rec_count,
  output logic [CNT_W-1:0]        X_wins,
  output logic [CNT_W-1:0]        Y_wins,
  output logic [CNT_W-1:0]        Z_wins,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    overflow
);

  edge_state_e        r_state;
  edge_state_e        w_state_nxt;
  logic               w_capture;
  winner_e            w_winner;
  log_rec_t           w_rec;
  log_rec_t           r_cap_rec;
  logic               r_cap_valid;
  logic [ROUND_W-1:0] r_round_id;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_drop;

`ifdef BIDS22_LOG_TIMESTAMP_EN
  logic [TS_W-1:0]    r_ts;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) r_ts <= '0;
    else                   r_ts <= r_ts + TS_W'(1);
  end
`endif

  // Edge FSM: one capture per high phase of roundOver; keeps tracking during clear.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (roundOver) begin
          w_state_nxt = ST_HELD;
          w_capture   = 1'b1;
        end
      end
      ST_HELD: begin
        if (!roundOver) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_winner       = decode_win(X_win, Y_win, Z_win);
    w_rec          = '0;
    w_rec.round_id = LOG_ROUND_W'(r_round_id);
    w_rec.winner   = w_winner;
    w_rec.amount   = (w_winner == WIN_NONE) ? '0 : maxBid;
`ifdef BIDS22_LOG_TIMESTAMP_EN
    w_rec.ts       = r_ts;
`endif
  end

  // Capture stage: record is staged one cycle, then pushed; round id and win counts move at capture.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_cap_valid <= 1'b0;
      r_cap_rec   <= '0;
      r_round_id  <= '0;
      X_wins      <= '0;
      Y_wins      <= '0;
      Z_wins      <= '0;
    end else begin
      r_cap_valid <= w_capture;
      if (w_capture) begin
        r_cap_rec  <= w_rec;
        r_round_id <= r_round_id + ROUND_W'(1);
        case (w_winner)
          WIN_X:   if (X_wins != '1) X_wins <= X_wins + CNT_W'(1);
          WIN_Y:   if (Y_wins != '1) Y_wins <= Y_wins + CNT_W'(1);
          WIN_Z:   if (Z_wins != '1) Z_wins <= Z_wins + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign rec_valid = !w_empty;
  assign w_pop     = rec_valid && rec_ready;
  assign w_drop    = r_cap_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (w_drop) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      overflow <= 1'b1;
    end
  end

  bids22_log_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (clear),
    .i_push  (r_cap_valid),
    .i_data  (r_cap_rec),
    .i_pop   (w_pop),
    .o_data  (rec_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (rec_count)
  );

endmodule

// File: tb/tb_bids22_result_log.sv
// Self-checking bench for bids22_result_log: directed scenarios plus randomized traffic vs a queue model.
module tb_bids22_result_log;
  import bids22_log_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clear;
  logic              roundOver;
  logic              X_win, Y_win, Z_win;
  logic [31:0]       maxBid;
  logic              rec_valid;
  logic              rec_ready;
  logic [REC_W-1:0]  rec_data;
  logic [CW-1:0]     rec_count;
  logic [CNT_W-1:0]  X_wins, Y_wins, Z_wins, drop_cnt;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  bids22_result_log #(.DEPTH(DEPTH), .ROUND_W(8), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .roundOver (roundOver),
    .X_win     (X_win),
    .Y_win     (Y_win),
    .Z_win     (Z_win),
    .maxBid    (maxBid),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .rec_count (rec_count),
    .X_wins    (X_wins),
    .Y_wins    (Y_wins),
    .Z_wins    (Z_wins),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of records plus a one-cycle staging slot between capture and enqueue.
  log_rec_t m_q[$];
  bit       m_prev;
  bit       m_pend;
  log_rec_t m_pend_rec;
  int       m_round, m_xw, m_yw, m_zw, m_drop, m_ts;
  bit       m_ovf;

  always @(posedge clk) begin : model
    bit       full;
    bit       pop;
    int       nwin;
    log_rec_t r;
    if (!reset_n || clear) begin
      m_q.delete();
      m_prev  = reset_n ? roundOver : 1'b0;
      m_pend  = 1'b0;
      m_round = 0; m_xw = 0; m_yw = 0; m_zw = 0; m_drop = 0; m_ts = 0;
      m_ovf   = 1'b0;
    end else begin
      full = (m_q.size() == DEPTH);
      pop  = (m_q.size() != 0) && rec_ready;
      if (pop) void'(m_q.pop_front());
      if (m_pend) begin
        if (!full || pop) m_q.push_back(m_pend_rec);
        else begin
          if (m_drop < CMAX) m_drop++;
          m_ovf = 1'b1;
        end
      end
      m_pend = roundOver && !m_prev;
      m_prev = roundOver;
      if (m_pend) begin
        nwin = int'(X_win) + int'(Y_win) + int'(Z_win);
        r = '0;
        r.round_id = 8'(m_round % 256);
        if (nwin == 0)      r.winner = WIN_NONE;
        else if (nwin > 1)  r.winner = WIN_MULTI;
        else if (X_win)     r.winner = WIN_X;
        else if (Y_win)     r.winner = WIN_Y;
        else                r.winner = WIN_Z;
        r.amount = (nwin == 0) ? 32'd0 : maxBid;
`ifdef BIDS22_LOG_TIMESTAMP_EN
        r.ts = 16'(m_ts % 65536);
`endif
        m_pend_rec = r;
        m_round++;
        if (nwin == 1) begin
          if (X_win && m_xw < CMAX) m_xw++;
          if (Y_win && m_yw < CMAX) m_yw++;
          if (Z_win && m_zw < CMAX) m_zw++;
        end
      end
      m_ts++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
    rec_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; roundOver = 1'b1; X_win = 1'b1; Y_win = 1'b0; Z_win = 1'b0;
    maxBid = 32'hDEAD_BEEF; rec_ready = 1'b1;
    tick(); tick();
    checks++;
    if (rec_valid !== 1'b0 || rec_data !== '0 || rec_count !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_fifo got valid=%b data=%h count=%0d ovf=%b exp all 0",
               rec_valid, rec_data, rec_count, overflow);
    end
    checks++;
    if (X_wins !== '0 || Y_wins !== '0 || Z_wins !== '0 || drop_cnt !== '0) begin
      failures++;
      $display("FAIL reset_counters got x=%0d y=%0d z=%0d drop=%0d exp 0", X_wins, Y_wins, Z_wins, drop_cnt);
    end
    roundOver = 1'b0; X_win = 1'b0; rec_ready = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_round();
    log_rec_t r;
    do_clear();
    roundOver = 1'b1; X_win = 1'b1; maxBid = 32'h64;
    tick();
    checks++;
    if (rec_valid !== 1'b0) begin
      failures++; $display("FAIL latency_early got valid=%b exp 0", rec_valid);
    end
    X_win = 1'b0; maxBid = $urandom;
    tick();
    r = log_rec_t'(rec_data);
    checks++;
    if (rec_valid !== 1'b1 || r.round_id !== 8'd0 || r.winner !== WIN_X || r.amount !== 32'h64) begin
      failures++;
      $display("FAIL single_rec got valid=%b id=%0d win=%0d amt=%h exp 1 0 1 64",
               rec_valid, r.round_id, r.winner, r.amount);
    end
    tick();
    roundOver = 1'b0;
    tick(); tick();
    r = log_rec_t'(rec_data);
    checks++;
    if (rec_count !== CW'(1) || X_wins !== CNT_W'(1) || r.amount !== 32'h64 || r.winner !== WIN_X) begin
      failures++;
      $display("FAIL single_nodup_hold got count=%0d xw=%0d amt=%h exp 1 1 64", rec_count, X_wins, r.amount);
    end
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    checks++;
    if (rec_valid !== 1'b0 || rec_count !== '0) begin
      failures++; $display("FAIL single_pop got valid=%b count=%0d exp 0 0", rec_valid, rec_count);
    end
  endtask

  task automatic test_none_multi();
    log_rec_t r;
    do_clear();
    roundOver = 1'b1; maxBid = 32'h55;
    tick();
    roundOver = 1'b0;
    tick();
    roundOver = 1'b1; Y_win = 1'b1; Z_win = 1'b1; maxBid = 32'h20;
    tick(); tick();
    roundOver = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
    tick();
    r = log_rec_t'(rec_data);
    checks++;
    if (rec_count !== CW'(2) || r.round_id !== 8'd0 || r.winner !== WIN_NONE || r.amount !== 32'd0) begin
      failures++;
      $display("FAIL none_rec got count=%0d id=%0d win=%0d amt=%h exp 2 0 0 0",
               rec_count, r.round_id, r.winner, r.amount);
    end
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    r = log_rec_t'(rec_data);
    checks++;
    if (r.round_id !== 8'd1 || r.winner !== WIN_MULTI || r.amount !== 32'h20) begin
      failures++;
      $display("FAIL multi_rec got id=%0d win=%0d amt=%h exp 1 4 20", r.round_id, r.winner, r.amount);
    end
    checks++;
    if (Y_wins !== '0 || Z_wins !== '0 || X_wins !== '0) begin
      failures++; $display("FAIL multi_counters got y=%0d z=%0d x=%0d exp 0", Y_wins, Z_wins, X_wins);
    end
  endtask

  task automatic fill_rounds(input int n);
    for (int i = 0; i < n; i++) begin
      roundOver = 1'b1; X_win = 1'b1; maxBid = 32'(i);
      tick();
      roundOver = 1'b0; X_win = 1'b0;
      tick();
    end
  endtask

  task automatic test_overflow();
    log_rec_t r;
    do_clear();
    fill_rounds(9);
    checks++;
    if (rec_count !== CW'(8) || drop_cnt !== CNT_W'(1) || overflow !== 1'b1 || X_wins !== CNT_W'(9)) begin
      failures++;
      $display("FAIL overflow_state got count=%0d drop=%0d ovf=%b xw=%0d exp 8 1 1 9",
               rec_count, drop_cnt, overflow, X_wins);
    end
    for (int i = 0; i < 8; i++) begin
      r = log_rec_t'(rec_data);
      checks++;
      if (rec_valid !== 1'b1 || r.round_id !== 8'(i) || r.amount !== 32'(i)) begin
        failures++;
        $display("FAIL overflow_drain[%0d] got valid=%b id=%0d amt=%0d exp 1 %0d %0d",
                 i, rec_valid, r.round_id, r.amount, i, i);
      end
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
    end
    checks++;
    if (rec_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++; $display("FAIL overflow_empty got valid=%b ovf=%b exp 0 1", rec_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    log_rec_t r;
    do_clear();
    fill_rounds(8);
    roundOver = 1'b1; Y_win = 1'b1; maxBid = 32'hAB;
    tick();
    roundOver = 1'b0; Y_win = 1'b0; rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    checks++;
    if (rec_count !== CW'(8) || drop_cnt !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pushpop got count=%0d drop=%0d ovf=%b exp 8 0 0", rec_count, drop_cnt, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      r = log_rec_t'(rec_data);
      checks++;
      if (r.round_id !== 8'(i) ||
          (i == 8 && (r.winner !== WIN_Y || r.amount !== 32'hAB))) begin
        failures++;
        $display("FAIL full_order[%0d] got id=%0d win=%0d amt=%h", i, r.round_id, r.winner, r.amount);
      end
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
    end
  endtask

  task automatic test_wrap_clear();
    log_rec_t r;
    do_clear();
    rec_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      roundOver = 1'b1; X_win = 1'($urandom_range(0, 1)); maxBid = $urandom;
      tick();
      roundOver = 1'b0; X_win = 1'b0;
      tick();
      r = log_rec_t'(rec_data);
      checks++;
      if (rec_valid !== 1'b1 || r.round_id !== 8'(i % 256)) begin
        failures++;
        $display("FAIL wrap_id[%0d] got valid=%b id=%0d exp 1 %0d", i, rec_valid, r.round_id, i % 256);
      end
    end
    roundOver = 1'b1; X_win = 1'b1;
    tick();
    clear = 1'b1; roundOver = 1'b0; X_win = 1'b0;
    tick();
    clear = 1'b0;
    checks++;
    if (rec_valid !== 1'b0 || rec_count !== '0 || X_wins !== '0 || drop_cnt !== '0) begin
      failures++;
      $display("FAIL clear_now got valid=%b count=%0d xw=%0d drop=%0d exp 0", rec_valid, rec_count, X_wins, drop_cnt);
    end
    tick(); tick();
    checks++;
    if (rec_valid !== 1'b0) begin
      failures++; $display("FAIL clear_discard got valid=%b exp 0", rec_valid);
    end
    rec_ready = 1'b0;
    roundOver = 1'b1;
    tick();
    roundOver = 1'b0;
    tick();
    r = log_rec_t'(rec_data);
    checks++;
    if (rec_valid !== 1'b1 || r.round_id !== 8'd0) begin
      failures++; $display("FAIL clear_round_id got valid=%b id=%0d exp 1 0", rec_valid, r.round_id);
    end
  endtask

  task automatic test_reset_mid_round();
    log_rec_t r;
    do_clear();
    roundOver = 1'b1; Z_win = 1'b1; maxBid = 32'h77;
    tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (rec_count !== '0 || Z_wins !== '0) begin
      failures++; $display("FAIL midreset_zero got count=%0d zw=%0d exp 0 0", rec_count, Z_wins);
    end
    reset_n = 1'b1;
    tick();
    tick();
    r = log_rec_t'(rec_data);
    checks++;
    if (rec_count !== CW'(1) || r.round_id !== 8'd0 || r.winner !== WIN_Z || Z_wins !== CNT_W'(1)) begin
      failures++;
      $display("FAIL midreset_capture got count=%0d id=%0d win=%0d zw=%0d exp 1 0 3 1",
               rec_count, r.round_id, r.winner, Z_wins);
    end
    roundOver = 1'b0; Z_win = 1'b0;
    tick();
  endtask

`ifdef BIDS22_LOG_TIMESTAMP_EN
  task automatic test_timestamp();
    log_rec_t ra, rb;
    do_clear();
    roundOver = 1'b1;
    tick();
    roundOver = 1'b0;
    repeat (4) tick();
    roundOver = 1'b1;
    tick();
    roundOver = 1'b0;
    tick();
    ra = log_rec_t'(rec_data);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    rb = log_rec_t'(rec_data);
    checks++;
    if (16'(rb.ts - ra.ts) !== 16'd5) begin
      failures++; $display("FAIL timestamp_delta got %0d exp 5", 16'(rb.ts - ra.ts));
    end
  endtask
`endif

  task automatic test_random();
    log_rec_t exp_data;
    bit       exp_valid;
    for (int c = 0; c < 4000; c++) begin
      roundOver = 1'($urandom_range(0, 1));
      X_win     = ($urandom_range(0, 2) == 0);
      Y_win     = ($urandom_range(0, 2) == 0);
      Z_win     = ($urandom_range(0, 2) == 0);
      maxBid    = $urandom;
      rec_ready = ((c / 500) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 299) == 0);
      reset_n   = ($urandom_range(0, 699) != 0);
      tick();
      exp_valid = (m_q.size() != 0);
      exp_data  = exp_valid ? m_q[0] : '0;
      checks++;
      if (rec_valid !== exp_valid || rec_data !== exp_data || rec_count !== CW'(m_q.size())) begin
        failures++;
        $display("FAIL rand_fifo[%0d] got valid=%b data=%h count=%0d exp %b %h %0d",
                 c, rec_valid, rec_data, rec_count, exp_valid, exp_data, m_q.size());
      end
      checks++;
      if (X_wins !== CNT_W'(m_xw) || Y_wins !== CNT_W'(m_yw) || Z_wins !== CNT_W'(m_zw)) begin
        failures++;
        $display("FAIL rand_wins[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d",
                 c, X_wins, Y_wins, Z_wins, m_xw, m_yw, m_zw);
      end
      checks++;
      if (drop_cnt !== CNT_W'(m_drop) || overflow !== m_ovf) begin
        failures++;
        $display("FAIL rand_drop[%0d] got drop=%0d ovf=%b exp %0d %b", c, drop_cnt, overflow, m_drop, m_ovf);
      end
    end
    reset_n = 1'b1; clear = 1'b0; roundOver = 1'b0; rec_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; roundOver = 1'b0;
    X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0; maxBid = '0; rec_ready = 1'b0;
    test_reset();
    test_single_round();
    test_none_multi();
    test_overflow();
    test_full_push_pop();
    test_wrap_clear();
    test_reset_mid_round();
`ifdef BIDS22_LOG_TIMESTAMP_EN
    test_timestamp();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
